// File: rtl/dmem_ctrl_pkg.sv
// Shared types and codes for the data-memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_ctrl_pkg;

    localparam logic [31:0] DMEM_BASE_ADDR_DEF   = 32'h1001_0000;
    localparam int          DMEM_DEPTH_WORDS_DEF = 2048;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Store size codes; 2'b11 falls through to word.
    localparam logic [1:0] S_SW = 2'b00;
    localparam logic [1:0] S_SH = 2'b01;
    localparam logic [1:0] S_SB = 2'b10;

    // Load type codes; 3'b101..3'b111 fall through to word.
    localparam logic [2:0] L_LW  = 3'b000;
    localparam logic [2:0] L_LH  = 3'b001;
    localparam logic [2:0] L_LHU = 3'b010;
    localparam logic [2:0] L_LB  = 3'b011;
    localparam logic [2:0] L_LBU = 3'b100;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } acc_size_t;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_LD  = 1'b1;

    // Collapse the store/load codes into an access width.
    function automatic acc_size_t acc_size(input logic we, input logic [1:0] s_mux,
                                           input logic [2:0] l_mux);
        acc_size_t sz;
        sz = SZ_WORD;
        if (we) begin
            if (s_mux == S_SH)      sz = SZ_HALF;
            else if (s_mux == S_SB) sz = SZ_BYTE;
        end else begin
            if (l_mux == L_LH || l_mux == L_LHU)      sz = SZ_HALF;
            else if (l_mux == L_LB || l_mux == L_LBU) sz = SZ_BYTE;
        end
        return sz;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Bundle of the CPU port, loader port and memory-side signals of dmem_ctrl.
// Latency: n/a (wiring only).
// Backpressure: requests are held by the requester until its ready pulse.
interface dmem_ctrl_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_s_mux;
    logic [2:0]  cpu_l_mux;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_err;

    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_ready;
    logic [31:0] ld_rdata;
    logic        ld_err;

    logic        mem_wena;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Controller side.
    modport slave (
        input  cpu_req, cpu_we, cpu_s_mux, cpu_l_mux, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata, cpu_err,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_ready, ld_rdata, ld_err,
        output mem_wena, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester / memory-model side.
    modport master (
        output cpu_req, cpu_we, cpu_s_mux, cpu_l_mux, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata, cpu_err,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_ready, ld_rdata, ld_err,
        input  mem_wena, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_lane.sv
// Byte/half lane logic: load extract+extend and sub-word store merge.
// Latency: combinational.
// Backpressure: none.
module dmem_lane
    import dmem_ctrl_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  s_mux_i,
    input  logic [2:0]  l_mux_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] l);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = off[1] ? w[31:16] : w[15:0];
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        case (l)
            L_LH:    r = {{16{h[15]}}, h};
            L_LHU:   r = {16'h0000, h};
            L_LB:    r = {{24{b[7]}}, b};
            L_LBU:   r = {24'h000000, b};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] off, input logic [1:0] s);
        logic [31:0] r;
        r = w;
        case (s)
            S_SH: begin
                if (off[1]) r[31:16] = d[15:0];
                else        r[15:0]  = d[15:0];
            end
            S_SB: begin
                case (off)
                    2'd0:    r[7:0]   = d[7:0];
                    2'd1:    r[15:8]  = d[7:0];
                    2'd2:    r[23:16] = d[7:0];
                    default: r[31:24] = d[7:0];
                endcase
            end
            default: r = d;
        endcase
        return r;
    endfunction

    assign load_o  = extract(rd_word_i, offset_i, l_mux_i);
    assign merge_o = merge(old_word_i, wdata_i, offset_i, s_mux_i);

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port (CPU + loader) data-memory controller with round-robin arbitration.
// Latency: request to ready 3 cycles (lw/lh/lb/sw, errors), 4 cycles for sh/sb.
// Backpressure: requester holds req until its ready; the loser waits in IDLE.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR_DEF,
    parameter int          DEPTH_WORDS = DMEM_DEPTH_WORDS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    dmem_ctrl_if.slave bus
);

    state_t      state_q, state_d;
    logic        last_grant_q;
    logic [31:0] addr_q, wdata_q, word_q;
    logic        we_q, err_q;
    logic [1:0]  s_mux_q;
    logic [2:0]  l_mux_q;
    acc_size_t   size_q;

    logic        cpu_ready_q, cpu_ready_d, cpu_err_q, cpu_err_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic        ld_ready_q, ld_ready_d, ld_err_q, ld_err_d;
    logic [31:0] ld_rdata_q, ld_rdata_d;

    logic        mem_wena_c;
    logic [31:0] mem_addr_c, mem_wdata_c;
    logic [31:0] load_word, merge_word;

    // A port whose ready is pulsing still shows the request it just completed.
    logic cpu_pend, ld_pend, grant_ld;
    assign cpu_pend = bus.cpu_req & ~cpu_ready_q;
    assign ld_pend  = bus.ld_req & ~ld_ready_q;
    assign grant_ld = ld_pend & (~cpu_pend | (last_grant_q == GNT_CPU));

    // Winner's request fields; the loader port is always a word access.
    logic        sel_we, sel_err, sel_below, sel_over, sel_misal;
    logic [1:0]  sel_s;
    logic [2:0]  sel_l;
    logic [31:0] sel_addr, sel_wdata, sel_off;
    acc_size_t   sel_size;

    assign sel_we    = grant_ld ? bus.ld_we    : bus.cpu_we;
    assign sel_s     = grant_ld ? S_SW         : bus.cpu_s_mux;
    assign sel_l     = grant_ld ? L_LW         : bus.cpu_l_mux;
    assign sel_addr  = grant_ld ? bus.ld_addr  : bus.cpu_addr;
    assign sel_wdata = grant_ld ? bus.ld_wdata : bus.cpu_wdata;
    assign sel_size  = acc_size(sel_we, sel_s, sel_l);
    assign sel_off   = sel_addr - BASE_ADDR;
    assign sel_below = sel_addr < BASE_ADDR;
    assign sel_over  = {2'b00, sel_off[31:2]} >= 32'(DEPTH_WORDS);
    assign sel_misal = ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00)) ||
                       ((sel_size == SZ_HALF) && sel_addr[0]);
    assign sel_err   = sel_below | sel_over | sel_misal;

    dmem_lane u_lane (
        .rd_word_i  (bus.mem_rdata),
        .old_word_i (word_q),
        .wdata_i    (wdata_q),
        .offset_i   (addr_q[1:0]),
        .s_mux_i    (s_mux_q),
        .l_mux_i    (l_mux_q),
        .load_o     (load_word),
        .merge_o    (merge_word)
    );

    // FSM state register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: errors and full-word/load accesses skip MERGE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cpu_pend | ld_pend) state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (!err_q && we_q && (size_q != SZ_WORD)) state_d = ST_MERGE;
                else                                        state_d = ST_RESP;
            end
            ST_MERGE:  state_d = ST_RESP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs: memory strobes only in ACCESS/MERGE, port responses staged in RESP.
    always_comb begin
        mem_wena_c  = 1'b0;
        mem_addr_c  = 32'h0;
        mem_wdata_c = 32'h0;
        cpu_ready_d = 1'b0;
        cpu_err_d   = cpu_err_q;
        cpu_rdata_d = cpu_rdata_q;
        ld_ready_d  = 1'b0;
        ld_err_d    = ld_err_q;
        ld_rdata_d  = ld_rdata_q;
        case (state_q)
            ST_ACCESS: begin
                mem_addr_c = addr_q;
                if (we_q && !err_q && (size_q == SZ_WORD)) begin
                    mem_wena_c  = 1'b1;
                    mem_wdata_c = wdata_q;
                end
            end
            ST_MERGE: begin
                mem_addr_c  = addr_q;
                mem_wena_c  = 1'b1;
                mem_wdata_c = merge_word;
            end
            ST_RESP: begin
                if (last_grant_q == GNT_LD) begin
                    ld_ready_d = 1'b1;
                    ld_err_d   = err_q;
                    ld_rdata_d = (!err_q && !we_q) ? word_q : 32'h0;
                end else begin
                    cpu_ready_d = 1'b1;
                    cpu_err_d   = err_q;
                    cpu_rdata_d = (!err_q && !we_q) ? word_q : 32'h0;
                end
            end
            default: ;
        endcase
    end

    // Datapath: latch the grant in IDLE, capture memory data in ACCESS, register responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GNT_LD;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            word_q       <= 32'h0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            s_mux_q      <= S_SW;
            l_mux_q      <= L_LW;
            size_q       <= SZ_WORD;
            cpu_ready_q  <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= 32'h0;
            ld_ready_q   <= 1'b0;
            ld_err_q     <= 1'b0;
            ld_rdata_q   <= 32'h0;
        end else begin
            if ((state_q == ST_IDLE) && (cpu_pend | ld_pend)) begin
                last_grant_q <= grant_ld;
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
                we_q         <= sel_we;
                err_q        <= sel_err;
                s_mux_q      <= sel_s;
                l_mux_q      <= sel_l;
                size_q       <= sel_size;
            end
            if ((state_q == ST_ACCESS) && !err_q)
                word_q <= we_q ? bus.mem_rdata : load_word;
            cpu_ready_q <= cpu_ready_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_ready_q  <= ld_ready_d;
            ld_err_q    <= ld_err_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    assign bus.mem_wena  = mem_wena_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.cpu_ready = cpu_ready_q;
    assign bus.cpu_err   = cpu_err_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ld_ready  = ld_ready_q;
    assign bus.ld_err    = ld_err_q;
    assign bus.ld_rdata  = ld_rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: behavioural memory, reference model and response scoreboard.
// Latency: checked per transaction against the expected 3/4 cycles.
// Backpressure: requests are held until the matching ready pulse.
module tb_dmem_ctrl;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_ctrl_if bus();

    dmem_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural memory ----------------
    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];
    logic        mem_clear = 1'b1;
    int          wena_cnt  = 0;
    int          ready_cnt = 0;
    int          grant_log[$];
    logic [31:0] mem_off;

    function automatic bit in_range(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return (a >= BASE) && ((o >> 2) < 32'(DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] o;
        o = (a - BASE) >> 2;
        return int'(o);
    endfunction

    assign mem_off = bus.mem_addr - BASE;

    always_comb begin
        bus.mem_rdata = 32'h0;
        if (in_range(bus.mem_addr)) bus.mem_rdata = mem[int'(mem_off[31:2])];
    end

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else if (bus.mem_wena) begin
            wena_cnt <= wena_cnt + 1;
            if (in_range(bus.mem_addr)) mem[int'(mem_off[31:2])] <= bus.mem_wdata;
        end
    end

    // ---------------- reference model ----------------
    function automatic int ref_size(input bit port, input bit we, input logic [1:0] s,
                                    input logic [2:0] l);
        if (port) return 0;
        if (we)   return (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : 0;
        return (l == 3'b001 || l == 3'b010) ? 1 : (l == 3'b011 || l == 3'b100) ? 2 : 0;
    endfunction

    function automatic bit ref_err(input logic [31:0] a, input int sz);
        if (!in_range(a)) return 1'b1;
        if (sz == 0) return a[1:0] != 2'b00;
        if (sz == 1) return a[0];
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] l);
        int          sh;
        logic [31:0] v;
        v = w;
        if (l == 3'b001 || l == 3'b010) begin
            sh = a[1] ? 16 : 0;
            v  = (w >> sh) & 32'h0000_FFFF;
            if (l == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        end else if (l == 3'b011 || l == 3'b100) begin
            sh = 8 * int'(a[1:0]);
            v  = (w >> sh) & 32'h0000_00FF;
            if (l == 3'b011 && v[7]) v = v | 32'hFFFF_FF00;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [31:0] a, input int sz);
        int          sh;
        logic [31:0] m;
        if (sz == 1)      begin sh = a[1] ? 16 : 0;    m = 32'h0000_FFFF << sh; end
        else if (sz == 2) begin sh = 8 * int'(a[1:0]); m = 32'h0000_00FF << sh; end
        else              begin sh = 0;                m = 32'hFFFF_FFFF;       end
        return (w & ~m) | ((d << sh) & m);
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t cpu_q[$];
    exp_t ld_q[$];

    always @(negedge clk) begin
        if (!rst && bus.cpu_ready) begin
            ready_cnt <= ready_cnt + 1;
            grant_log.push_back(0);
            chk("cpu_exp_avail", 32'(cpu_q.size() > 0), 32'd1);
            if (cpu_q.size() > 0) begin
                chk("cpu_rdata", bus.cpu_rdata, cpu_q[0].rdata);
                chk("cpu_err", 32'(bus.cpu_err), 32'(cpu_q[0].err));
                void'(cpu_q.pop_front());
            end
        end
        if (!rst && bus.ld_ready) begin
            ready_cnt <= ready_cnt + 1;
            grant_log.push_back(1);
            chk("ld_exp_avail", 32'(ld_q.size() > 0), 32'd1);
            if (ld_q.size() > 0) begin
                chk("ld_rdata", bus.ld_rdata, ld_q[0].rdata);
                chk("ld_err", 32'(bus.ld_err), 32'(ld_q[0].err));
                void'(ld_q.pop_front());
            end
        end
    end

    // One complete transaction on a port: model, drive, wait, check side effects.
    task automatic access(input bit port, input bit we, input logic [1:0] s,
                          input logic [2:0] l, input logic [31:0] a, input logic [31:0] d,
                          input string tag);
        int   sz, lat, w0, idx;
        bit   err;
        exp_t e;
        sz  = ref_size(port, we, s, l);
        err = ref_err(a, sz);
        idx = in_range(a) ? widx(a) : 0;
        e.rdata = 32'h0;
        e.err   = err;
        if (!err && !we) e.rdata = ref_load(ref_mem[idx], a, port ? 3'b000 : l);
        if (!err && we)  ref_mem[idx] = ref_store(ref_mem[idx], d, a, sz);
        if (port) ld_q.push_back(e);
        else      cpu_q.push_back(e);
        w0 = wena_cnt;
        if (port) begin
            bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = d; bus.ld_req = 1'b1;
        end else begin
            bus.cpu_we = we; bus.cpu_s_mux = s; bus.cpu_l_mux = l;
            bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_req = 1'b1;
        end
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (port ? bus.ld_ready : bus.cpu_ready) break;
        end
        bus.cpu_req = 1'b0;
        bus.ld_req  = 1'b0;
        chk({tag, "_lat"}, 32'(lat), (!err && we && sz != 0) ? 32'd4 : 32'd3);
        chk({tag, "_wena"}, 32'(wena_cnt - w0), (!err && we) ? 32'd1 : 32'd0);
        if (in_range(a)) chk({tag, "_mem"}, mem[idx], ref_mem[idx]);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(port ? bus.ld_ready : bus.cpu_ready), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   w0, r0, n, cyc;
        exp_t e;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_s_mux = 2'b00; bus.cpu_l_mux = 3'b000;
        bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
        bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = 32'h0; bus.ld_wdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("rst_mem_wena", 32'(bus.mem_wena), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        mem_clear = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Word store, readback.
        access(0, 1, 2'b00, 3'b000, 32'h1001_0004, 32'hDEAD_BEEF, "sw");
        access(0, 0, 2'b00, 3'b000, 32'h1001_0004, 32'h0, "lw");
        chk("lw_val", bus.cpu_rdata, 32'hDEAD_BEEF);

        // Loader preload, then byte merge and byte loads.
        access(1, 1, 2'b00, 3'b000, 32'h1001_0008, 32'h1122_3344, "ld_sw");
        access(0, 1, 2'b10, 3'b000, 32'h1001_000A, 32'h0000_00AA, "sb");
        chk("sb_word", mem[2], 32'h11AA_3344);
        access(0, 0, 2'b00, 3'b011, 32'h1001_000A, 32'h0, "lb");
        chk("lb_val", bus.cpu_rdata, 32'hFFFF_FFAA);
        access(0, 0, 2'b00, 3'b100, 32'h1001_000A, 32'h0, "lbu");
        chk("lbu_val", bus.cpu_rdata, 32'h0000_00AA);

        // Halfword loads/stores.
        access(0, 0, 2'b00, 3'b001, 32'h1001_000A, 32'h0, "lh_hi");
        access(0, 0, 2'b00, 3'b010, 32'h1001_0008, 32'h0, "lhu_lo");
        access(0, 1, 2'b01, 3'b000, 32'h1001_0008, 32'hFFFF_8001, "sh");
        chk("sh_word", mem[2], 32'h11AA_8001);
        access(0, 0, 2'b00, 3'b001, 32'h1001_0008, 32'h0, "lh_neg");
        chk("lh_neg_val", bus.cpu_rdata, 32'hFFFF_8001);

        // Error cases.
        access(0, 0, 2'b00, 3'b001, 32'h1001_0001, 32'h0, "lh_mis");
        chk("lh_mis_err", 32'(bus.cpu_err), 32'd1);
        access(0, 1, 2'b00, 3'b000, 32'h1001_2000, 32'h5555_5555, "sw_oor");
        chk("sw_oor_err", 32'(bus.cpu_err), 32'd1);
        access(0, 1, 2'b00, 3'b000, 32'h1001_0006, 32'h7777_7777, "sw_mis");
        access(0, 0, 2'b00, 3'b000, 32'h1000_FFFC, 32'h0, "lw_below");
        access(1, 0, 2'b00, 3'b000, 32'h1001_0002, 32'h0, "ld_lw_mis");

        // Reserved codes fall back to word accesses.
        access(0, 1, 2'b11, 3'b000, 32'h1001_000C, 32'hCAFE_F00D, "sw_s11");
        access(0, 0, 2'b00, 3'b111, 32'h1001_0004, 32'h0, "lw_l111");
        access(1, 0, 2'b00, 3'b000, 32'h1001_0008, 32'h0, "ld_lw");
        chk("cpu_rdata_hold", bus.cpu_rdata, 32'hDEAD_BEEF);

        // Reset in the middle of a halfword merge.
        w0 = wena_cnt;
        r0 = ready_cnt;
        bus.cpu_we = 1'b1; bus.cpu_s_mux = 2'b01; bus.cpu_l_mux = 3'b000;
        bus.cpu_addr = 32'h1001_000E; bus.cpu_wdata = 32'h0000_1234; bus.cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("rm_merge_wena", 32'(bus.mem_wena), 32'd1);
        rst = 1'b1;
        #1;
        chk("rm_async_wena", 32'(bus.mem_wena), 32'd0);
        chk("rm_async_addr", bus.mem_addr, 32'h0);
        bus.cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rm_rst_rdata", bus.cpu_rdata, 32'h0);
        chk("rm_rst_ready", 32'(bus.cpu_ready), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rm_no_ready", 32'(ready_cnt - r0), 32'd0);
        chk("rm_no_wena", 32'(wena_cnt - w0), 32'd0);
        chk("rm_word", mem[3], 32'hCAFE_F00D);

        // Both ports held: grants alternate starting with the CPU.
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            e.rdata = 32'hDEAD_BEEF; e.err = 1'b0; cpu_q.push_back(e);
            e.rdata = 32'hCAFE_F00D; e.err = 1'b0; ld_q.push_back(e);
        end
        bus.cpu_we = 1'b0; bus.cpu_l_mux = 3'b000; bus.cpu_addr = 32'h1001_0004;
        bus.ld_we = 1'b0; bus.ld_addr = 32'h1001_000C;
        bus.cpu_req = 1'b1;
        bus.ld_req  = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 6 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (bus.cpu_ready || bus.ld_ready) n++;
        end
        bus.cpu_req = 1'b0;
        bus.ld_req  = 1'b0;
        repeat (3) @(negedge clk);
        chk("alt_count", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < grant_log.size() && i < 6; i++)
            chk($sformatf("alt_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));
        chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        chk("ld_q_drained", 32'(ld_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
